// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load handshake, a stall input and an end-of-word pulse.
// Accepting a new word on the last-bit cycle lets consecutive words stream with no gap between them.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     clear_n_i,
    input  logic                     load_valid_i,
    output logic                     load_ready_o,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     si_i,
    input  logic                     shift_en_i,
    output logic                     sout_o,
    output logic                     sout_valid_o,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(WIDTH)-1:0] bit_cnt_o,
    output logic                     done_o
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             head_bit;

    // Register contents after one bit is consumed; si fills the vacated end.
    always_comb begin
        if (LSB_FIRST) begin
            shifted  = {si_i, reg_q[WIDTH-1:1]};
            head_bit = reg_q[0];
        end else begin
            shifted  = {reg_q[WIDTH-2:0], si_i};
            head_bit = reg_q[WIDTH-1];
        end
    end

    assign last_bit     = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT) && shift_en_i;
    assign load_ready_o = (state_q == ST_IDLE) || last_bit;

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid_i) begin
                    reg_d   = din_i;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    if (load_valid_i) begin
                        reg_d = din_i;
                    end else begin
                        reg_d   = shifted;
                        state_d = ST_IDLE;
                    end
                end else if (shift_en_i) begin
                    reg_d = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!clear_n_i) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign sout_valid_o = (state_q == ST_SHIFT);
    assign sout_o       = (state_q == ST_SHIFT) & head_bit;
    assign dout_o       = reg_q;
    assign bit_cnt_o    = cnt_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first 4-bit instances and a 5-bit instance
// share control inputs; each scenario resets everything and checks the instance it targets.
module tb_piso_serializer;

    logic       clk;
    logic       clear_n;
    logic       load_valid;
    logic       si;
    logic       shift_en;
    logic [3:0] din4;
    logic [4:0] din5;

    logic       l_ready, l_sout, l_valid, l_done;
    logic [3:0] l_dout;
    logic [1:0] l_cnt;
    logic       m_ready, m_sout, m_valid, m_done;
    logic [3:0] m_dout;
    logic [1:0] m_cnt;
    logic       f_ready, f_sout, f_valid, f_done;
    logic [4:0] f_dout;
    logic [2:0] f_cnt;

    int total = 0;
    int bad   = 0;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_l (
        .clk_i(clk), .clear_n_i(clear_n), .load_valid_i(load_valid), .load_ready_o(l_ready),
        .din_i(din4), .si_i(si), .shift_en_i(shift_en), .sout_o(l_sout), .sout_valid_o(l_valid),
        .dout_o(l_dout), .bit_cnt_o(l_cnt), .done_o(l_done)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_m (
        .clk_i(clk), .clear_n_i(clear_n), .load_valid_i(load_valid), .load_ready_o(m_ready),
        .din_i(din4), .si_i(si), .shift_en_i(shift_en), .sout_o(m_sout), .sout_valid_o(m_valid),
        .dout_o(m_dout), .bit_cnt_o(m_cnt), .done_o(m_done)
    );

    piso_serializer #(.WIDTH(5), .LSB_FIRST(1'b1)) u_f (
        .clk_i(clk), .clear_n_i(clear_n), .load_valid_i(load_valid), .load_ready_o(f_ready),
        .din_i(din5), .si_i(si), .shift_en_i(shift_en), .sout_o(f_sout), .sout_valid_o(f_valid),
        .dout_o(f_dout), .bit_cnt_o(f_cnt), .done_o(f_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_n    = 1'b0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        si         = 1'b0;
        step();
        clear_n = 1'b1;
    endtask

    logic [3:0] exp_l [4];
    logic [3:0] exp_b [8];
    logic [4:0] exp_f [5];

    initial begin
        clear_n = 1'b0; load_valid = 1'b0; si = 1'b0; shift_en = 1'b0;
        din4 = '0; din5 = '0;

        // Reset state
        do_reset();
        chk("rst_sout", l_sout, 0);
        chk("rst_valid", l_valid, 0);
        chk("rst_done", l_done, 0);
        chk("rst_ready", l_ready, 1);
        chk("rst_dout", l_dout, 0);
        chk("rst_cnt", l_cnt, 0);

        // LSB-first 4'b1010, si=1: 0,1,0,1 then done and dout=1111
        exp_l = '{4'd0, 4'd1, 4'd0, 4'd1};
        din4 = 4'b1010; si = 1'b1; shift_en = 1'b1; load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            load_valid = 1'b0;
            chk($sformatf("lsb_sout%0d", i), l_sout, exp_l[i]);
            chk($sformatf("lsb_valid%0d", i), l_valid, 1);
            chk($sformatf("lsb_cnt%0d", i), l_cnt, i);
            chk($sformatf("lsb_done%0d", i), l_done, 0);
        end
        step();
        chk("lsb_done_pulse", l_done, 1);
        chk("lsb_valid_end", l_valid, 0);
        chk("lsb_sout_end", l_sout, 0);
        chk("lsb_dout_fill", l_dout, 4'b1111);
        chk("lsb_cnt_wrap", l_cnt, 0);
        step();
        chk("lsb_done_drop", l_done, 0);

        // MSB-first 4'b1100: 1,1,0,0
        do_reset();
        exp_l = '{4'd1, 4'd1, 4'd0, 4'd0};
        din4 = 4'b1100; shift_en = 1'b1; load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            load_valid = 1'b0;
            chk($sformatf("msb_sout%0d", i), m_sout, exp_l[i]);
            chk($sformatf("msb_cnt%0d", i), m_cnt, i);
        end
        step();
        chk("msb_done_pulse", m_done, 1);
        chk("msb_valid_end", m_valid, 0);

        // Stall after the second bit; a load offered while stalled must be ignored
        do_reset();
        din4 = 4'b1100; shift_en = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("stall_b0", m_sout, 1);
        step();
        chk("stall_b1", m_sout, 1);
        chk("stall_b1_cnt", m_cnt, 1);
        shift_en = 1'b0; load_valid = 1'b1; din4 = 4'b0101;
        chk("stall_ready", m_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_sout%0d", i), m_sout, 1);
            chk($sformatf("stall_cnt%0d", i), m_cnt, 1);
            chk($sformatf("stall_dout%0d", i), m_dout, 4'b1000);
            chk($sformatf("stall_done%0d", i), m_done, 0);
        end
        load_valid = 1'b0; shift_en = 1'b1;
        step();
        chk("stall_b2", m_sout, 0);
        chk("stall_b2_cnt", m_cnt, 2);
        step();
        chk("stall_b3", m_sout, 0);
        step();
        chk("stall_done_pulse", m_done, 1);
        chk("stall_idle", m_valid, 0);
        step();
        chk("stall_done_once", m_done, 0);

        // Back-to-back 4'hA then 4'hC, LSB-first
        do_reset();
        exp_b = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
        din4 = 4'hA; shift_en = 1'b1; load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            load_valid = 1'b0;
            chk($sformatf("b2b_sout%0d", i), l_sout, exp_b[i]);
            chk($sformatf("b2b_valid%0d", i), l_valid, 1);
            chk($sformatf("b2b_done%0d", i), l_done, (i == 4) ? 1 : 0);
            if (i == 3) begin
                chk("b2b_ready_last", l_ready, 1);
                din4 = 4'hC;
                load_valid = 1'b1;
            end
        end
        step();
        chk("b2b_done2", l_done, 1);
        chk("b2b_valid_end", l_valid, 0);

        // Reset mid-word of 4'hF with a load offered during the reset cycle
        do_reset();
        din4 = 4'hF; shift_en = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        chk("mid_sout_b1", l_sout, 1);
        clear_n = 1'b0; load_valid = 1'b1;
        step();
        chk("mid_valid", l_valid, 0);
        chk("mid_cnt", l_cnt, 0);
        chk("mid_done", l_done, 0);
        chk("mid_dout", l_dout, 0);
        chk("mid_ready", l_ready, 1);
        clear_n = 1'b1; load_valid = 1'b0;
        step();
        chk("mid_not_captured", l_valid, 0);
        chk("mid_done_after", l_done, 0);

        // WIDTH=5: 5'b10011 LSB-first -> 1,1,0,0,1 with bit_cnt 0..4 then wrap
        do_reset();
        exp_f = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd1};
        din5 = 5'b10011; shift_en = 1'b1; load_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            load_valid = 1'b0;
            chk($sformatf("w5_sout%0d", i), f_sout, exp_f[i]);
            chk($sformatf("w5_cnt%0d", i), f_cnt, i);
            chk($sformatf("w5_done%0d", i), f_done, 0);
        end
        step();
        chk("w5_cnt_wrap", f_cnt, 0);
        chk("w5_done_pulse", f_done, 1);
        chk("w5_valid_end", f_valid, 0);
        step();
        chk("w5_done_once", f_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, bit counter, selectable shift direction, stall input and end-of-word pulse. Successor to the fixed 4-bit load/shift register. Converts WIDTH-bit parallel words into a gapless serial bit stream for downstream serial links and test pattern generators.

## Interface
- WIDTH, 8, word width in bits; legal range 2 to 64.
- LSB_FIRST, 1, shift direction.
  - 1: din[0] is transmitted first and the register shifts right.
  - 0: din[WIDTH-1] is transmitted first and the register shifts left.
- clk  input  1  clock; all state changes on the rising edge.
- clear_n  input  1  reset, synchronous and active-low.
- load_valid  input  1  a parallel word is offered on din.
- load_ready  output  1  the block can accept a word this cycle.
- din  input  WIDTH  parallel word.
- si  input  1  fill bit shifted into the vacated end on every shift.
- shift_en  input  1  the downstream consumer takes the current bit this cycle; 0 means stall.
- sout  output  1  current serial bit; forced to 0 when sout_valid=0.
- sout_valid  output  1  sout carries a payload bit.
- dout  output  WIDTH  live shift-register contents, for readback and debug.
- bit_cnt  output  $clog2(WIDTH)  index of the current bit within the word.
- done  output  1  one-cycle pulse after the last bit of a word is consumed.

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1, sout_valid=0.
  - load_valid=1 → capture din into the register, bit_cnt←0, go to SHIFT.
- SHIFT:
  - sout_valid=1.
  - sout = reg[0] when LSB_FIRST=1, otherwise reg[WIDTH-1].
- SHIFT with shift_en=1 (bit consumed):
  - LSB_FIRST=1: reg ← {si, reg[WIDTH-1:1]}.
  - LSB_FIRST=0: reg ← {reg[WIDTH-2:0], si}.
  - bit_cnt increments.
- SHIFT with shift_en=0: reg, bit_cnt and state hold; sout stays stable.
- Last-bit cycle is defined as state=SHIFT, bit_cnt=WIDTH-1 and shift_en=1.
  - load_ready=1 in this cycle, in addition to IDLE.
  - With load_valid=1: load the new word, bit_cnt←0, stay in SHIFT. No bubble between words.
  - With load_valid=0: shift in si, go to IDLE, bit_cnt←0.
  - Either way, done=1 in the following cycle for exactly one cycle.
- load_ready is combinational from state, bit_cnt and shift_en. It is asserted nowhere else in SHIFT; load_valid outside a ready cycle is ignored and does not corrupt the register.
- bit_cnt never exceeds WIDTH-1. It wraps to 0 on word completion, including when WIDTH is not a power of two.

## Timing
- Reset: clear_n=0 sampled at a rising edge →
  - state=IDLE, reg=0, bit_cnt=0, done=0, sout_valid=0, sout=0, dout=0.
  - Reset takes priority over load_valid, shift_en and any operation in progress; a word mid-shift is discarded.
  - During the reset cycle, load_valid is not accepted. After the reset edge the block is in IDLE, so load_ready=1.
- Load to first bit latency: 1 cycle. A word accepted at edge N has its first bit on sout from edge N onward, with sout_valid=1.
- A word occupies exactly WIDTH cycles with shift_en=1; stall cycles add one-for-one.
- done asserts on the edge that completes the last bit and deasserts on the next edge.
- Continuous throughput is 1 bit per clock with back-to-back loads.
- dout reflects the register after each edge. After a word completes with no new load, dout holds WIDTH-1-dependent si fill bits and the first fill bit at the far end.

## Test plan
- Reset → sout=0, sout_valid=0, done=0, load_ready=1, dout=0. Then, with WIDTH=4, LSB_FIRST=1:
  - Load din=4'b1010 with shift_en=1 and si=1 → sout=0,1,0,1 on four consecutive cycles, done pulses on the 5th cycle, and dout=4'b1111.
- WIDTH=4, LSB_FIRST=0, din=4'b1100, shift_en held at 1 → sout=1,1,0,0.
- Stall: same load, shift_en=0 for 3 cycles after the second bit → sout holds 1 and bit_cnt holds 1 through the stall. The word completes after 7 cycles and done pulses once.
- Back-to-back: load 4'hA, then 4'hC presented on the last-bit cycle → 8 contiguous valid bits 0,1,0,1,0,0,1,1, done pulses after bit 4 and after bit 8, and sout_valid never drops.
- Reset mid-word: clear_n=0 after 2 bits of 4'hF → next cycle state is IDLE, sout_valid=0, bit_cnt=0, and no done pulse. load_valid asserted during the reset cycle is not captured.
- WIDTH=5 (non-power-of-two): load 5'b10011 → bit_cnt goes 0 to 4 and wraps to 0, sout=1,1,0,0,1, done pulses once.
